// File: rtl/mem_b_arbiter.sv
// mem_b_arbiter: shares block-RAM port B between the VGA reader (client 0),
// the SNES poller (client 1) and the debug loader (client 2).
// Client 0 has fixed priority. Clients 1 and 2 alternate between themselves and
// override client 0 once they have waited MAX_WAIT cycles. A client can lock the
// port to get back-to-back grants.
module mem_b_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [2:0]            lock,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [ADDR_WIDTH-1:0] addr2,
    input  logic [15:0]           wdata0,
    input  logic [15:0]           wdata1,
    input  logic [15:0]           wdata2,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [15:0]           rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr_b,
    output logic [15:0]           mem_data_b,
    output logic                  mem_w_en_b,
    input  logic [15:0]           mem_q_b
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0] r_wait1;
    logic [3:0] r_wait2;
    logic       r_rr;
    logic       r_lock_valid;
    logic [1:0] r_lock_owner;
    logic [2:0] r_rvalid;

    logic [2:0] w_gnt;
    logic       w_owner_req;
    logic       w_starve1;
    logic       w_starve2;

    assign w_starve1 = req[1] && (r_wait1 == WAIT_MAX);
    assign w_starve2 = req[2] && (r_wait2 == WAIT_MAX);

    // Is the current lock owner still requesting?
    always_comb begin
        w_owner_req = 1'b0;
        case (r_lock_owner)
            2'd0:    w_owner_req = req[0];
            2'd1:    w_owner_req = req[1];
            2'd2:    w_owner_req = req[2];
            default: w_owner_req = 1'b0;
        endcase
    end

    // Grant selection: lock, then starvation override, then client 0, then round-robin 1/2.
    always_comb begin
        w_gnt = 3'b000;
        if (!reset) begin
            w_gnt = 3'b000;
        end else if (r_lock_valid && w_owner_req) begin
            case (r_lock_owner)
                2'd0:    w_gnt = 3'b001;
                2'd1:    w_gnt = 3'b010;
                2'd2:    w_gnt = 3'b100;
                default: w_gnt = 3'b000;
            endcase
        end else if (w_starve1 && w_starve2) begin
            w_gnt = r_rr ? 3'b100 : 3'b010;
        end else if (w_starve1) begin
            w_gnt = 3'b010;
        end else if (w_starve2) begin
            w_gnt = 3'b100;
        end else if (req[0]) begin
            w_gnt = 3'b001;
        end else if (req[1] && req[2]) begin
            w_gnt = r_rr ? 3'b100 : 3'b010;
        end else if (req[1]) begin
            w_gnt = 3'b010;
        end else if (req[2]) begin
            w_gnt = 3'b100;
        end
    end

    // Route the granted client's address and data onto port B (zero when idle).
    always_comb begin
        mem_addr_b = '0;
        mem_data_b = 16'h0000;
        case (w_gnt)
            3'b001: begin mem_addr_b = addr0; mem_data_b = wdata0; end
            3'b010: begin mem_addr_b = addr1; mem_data_b = wdata1; end
            3'b100: begin mem_addr_b = addr2; mem_data_b = wdata2; end
            default: begin mem_addr_b = '0; mem_data_b = 16'h0000; end
        endcase
    end

    assign gnt        = w_gnt;
    assign mem_w_en_b = |(w_gnt & we);
    assign rvalid     = r_rvalid;
    assign rdata      = mem_q_b;

    // Read-valid flags and round-robin pointer follow the grant of this cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rvalid <= 3'b000;
            r_rr     <= 1'b0;
        end else begin
            r_rvalid <= w_gnt & ~we;
            if (w_gnt[1]) begin
                r_rr <= 1'b1;
            end else if (w_gnt[2]) begin
                r_rr <= 1'b0;
            end
        end
    end

    // Wait counters: count cycles spent requesting without a grant, saturating.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wait1 <= 4'd0;
            r_wait2 <= 4'd0;
        end else begin
            if (w_gnt[1] || !req[1]) begin
                r_wait1 <= 4'd0;
            end else if (r_wait1 != WAIT_MAX) begin
                r_wait1 <= r_wait1 + 4'd1;
            end
            if (w_gnt[2] || !req[2]) begin
                r_wait2 <= 4'd0;
            end else if (r_wait2 != WAIT_MAX) begin
                r_wait2 <= r_wait2 + 4'd1;
            end
        end
    end

    // Lock tracking: any grant re-evaluates the lock from that client's lock bit;
    // an owner that drops its request releases the port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lock_valid <= 1'b0;
            r_lock_owner <= 2'd0;
        end else if (|w_gnt) begin
            r_lock_valid <= |(w_gnt & lock);
            r_lock_owner <= w_gnt[2] ? 2'd2 : (w_gnt[1] ? 2'd1 : 2'd0);
        end else if (r_lock_valid && !w_owner_req) begin
            r_lock_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_b_arbiter.sv
// Directed table-driven bench for mem_b_arbiter with a behavioural block RAM.
module tb_mem_b_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req, we, lock;
    logic [11:0] addr0, addr1, addr2;
    logic [15:0] wdata0, wdata1, wdata2;
    logic [2:0]  gnt, rvalid;
    logic [15:0] rdata;
    logic [11:0] mem_addr_b;
    logic [15:0] mem_data_b;
    logic        mem_w_en_b;
    logic [15:0] mem_q_b;

    mem_b_arbiter #(.ADDR_WIDTH(12), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .lock(lock),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .mem_addr_b(mem_addr_b), .mem_data_b(mem_data_b),
        .mem_w_en_b(mem_w_en_b), .mem_q_b(mem_q_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous RAM on port B, with a bench-side preload port.
    logic [15:0] ram [0:4095];
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [15:0] ld_data;
    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (mem_w_en_b) ram[mem_addr_b] <= mem_data_b;
        mem_q_b <= ram[mem_addr_b];
    end

    typedef struct {
        logic        rst_n;
        logic [2:0]  req, we, lock;
        logic [11:0] a1, a2;
        logic [15:0] d2;
        logic [2:0]  e_gnt;
        logic        chk_rv;
        logic [2:0]  e_rv;
        logic [15:0] e_rdata;
        logic [11:0] e_addr;
        logic [15:0] e_data;
        logic        e_wen;
    } vec_t;

    vec_t tbl[$];
    int   n_err = 0;
    int   n_chk = 0;

    localparam logic [11:0] A0 = 12'h123;

    function automatic vec_t mk(input logic rst_n, input logic [2:0] r, input logic [2:0] w,
                                input logic [2:0] l, input logic [11:0] a1, input logic [11:0] a2,
                                input logic [15:0] d2, input logic [2:0] e_gnt,
                                input logic [2:0] e_rv, input logic [15:0] e_rdata);
        vec_t v;
        v.rst_n = rst_n; v.req = r; v.we = w; v.lock = l;
        v.a1 = a1; v.a2 = a2; v.d2 = d2;
        v.e_gnt = e_gnt; v.chk_rv = 1'b1; v.e_rv = e_rv; v.e_rdata = e_rdata;
        v.e_addr = (e_gnt == 3'b001) ? A0 : (e_gnt == 3'b010) ? a1 : (e_gnt == 3'b100) ? a2 : 12'h000;
        v.e_data = (e_gnt == 3'b100) ? d2 : 16'h0000;
        v.e_wen  = |(e_gnt & w);
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    // Drive one row for one cycle and compare outputs at the falling edge.
    task automatic apply(input int idx, input vec_t v);
        reset = v.rst_n; req = v.req; we = v.we; lock = v.lock;
        addr0 = A0; addr1 = v.a1; addr2 = v.a2;
        wdata0 = 16'h0000; wdata1 = 16'h0000; wdata2 = v.d2;
        @(negedge clk);
        chk("gnt", idx, 32'(gnt), 32'(v.e_gnt));
        chk("mem_addr_b", idx, 32'(mem_addr_b), 32'(v.e_addr));
        chk("mem_data_b", idx, 32'(mem_data_b), 32'(v.e_data));
        chk("mem_w_en_b", idx, 32'(mem_w_en_b), 32'(v.e_wen));
        if (v.chk_rv) chk("rvalid", idx, 32'(rvalid), 32'(v.e_rv));
        if (v.chk_rv && v.e_rv != 3'b000) chk("rdata", idx, 32'(rdata), 32'(v.e_rdata));
        $display("row %0d rst_n=%0b req=%03b we=%03b lock=%03b gnt=%03b rvalid=%03b addr=%03h rdata=%04h",
                 idx, v.rst_n, v.req, v.we, v.lock, gnt, rvalid, mem_addr_b, rdata);
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles; only the second has a known rvalid.
    task automatic add_reset();
        vec_t v;
        v = mk(1'b0, 3'b111, 3'b000, 3'b000, A0, A0, 16'h0, 3'b000, 3'b000, 16'h0);
        v.chk_rv = 1'b0;
        tbl.push_back(v);
        tbl.push_back(mk(1'b0, 3'b111, 3'b000, 3'b000, A0, A0, 16'h0, 3'b000, 3'b000, 16'h0));
    endtask

    initial begin
        reset = 1'b0; req = 3'b000; we = 3'b000; lock = 3'b000;
        addr0 = '0; addr1 = '0; addr2 = '0; wdata0 = '0; wdata1 = '0; wdata2 = '0;
        ld_en = 1'b1; ld_addr = 12'h123; ld_data = 16'hBEEF;
        @(posedge clk);
        #1;
        ld_en = 1'b0;

        // Single read by client 1.
        add_reset();
        tbl.push_back(mk(1, 3'b010, 3'b000, 3'b000, A0, A0, 16'h0, 3'b010, 3'b000, 16'h0));
        tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, A0, A0, 16'h0, 3'b000, 3'b010, 16'hBEEF));

        // Round-robin between clients 1 and 2, starting with client 1.
        add_reset();
        tbl.push_back(mk(1, 3'b110, 3'b000, 3'b000, A0, A0, 16'h0, 3'b010, 3'b000, 16'h0));
        tbl.push_back(mk(1, 3'b110, 3'b000, 3'b000, A0, A0, 16'h0, 3'b100, 3'b010, 16'hBEEF));
        tbl.push_back(mk(1, 3'b110, 3'b000, 3'b000, A0, A0, 16'h0, 3'b010, 3'b100, 16'hBEEF));
        tbl.push_back(mk(1, 3'b110, 3'b000, 3'b000, A0, A0, 16'h0, 3'b100, 3'b010, 16'hBEEF));
        tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, A0, A0, 16'h0, 3'b000, 3'b100, 16'hBEEF));

        // Client 0 priority, client 1 overrides after 8 waiting cycles.
        add_reset();
        for (int k = 0; k < 10; k++) begin
            logic [2:0] r, g, rv;
            r  = (k == 9) ? 3'b001 : 3'b011;
            g  = (k == 8) ? 3'b010 : 3'b001;
            rv = (k == 0) ? 3'b000 : ((k == 9) ? 3'b010 : 3'b001);
            tbl.push_back(mk(1, r, 3'b000, 3'b000, A0, A0, 16'h0, g, rv, 16'hBEEF));
        end

        // Locked write burst by client 2 while client 0 waits, then read back.
        add_reset();
        tbl.push_back(mk(1, 3'b100, 3'b100, 3'b100, A0, 12'h0A0, 16'hC000, 3'b100, 3'b000, 16'h0));
        for (int k = 1; k < 4; k++) begin
            tbl.push_back(mk(1, 3'b101, 3'b100, (k == 3) ? 3'b000 : 3'b100, A0, 12'h0A0 + 12'(k),
                             16'hC000 + 16'(k), 3'b100, 3'b000, 16'h0));
        end
        tbl.push_back(mk(1, 3'b001, 3'b000, 3'b000, A0, A0, 16'h0, 3'b001, 3'b000, 16'h0));
        tbl.push_back(mk(1, 3'b010, 3'b000, 3'b000, 12'h0A0, A0, 16'h0, 3'b010, 3'b001, 16'hBEEF));
        for (int k = 1; k < 4; k++) begin
            tbl.push_back(mk(1, 3'b010, 3'b000, 3'b000, 12'h0A0 + 12'(k), A0, 16'h0, 3'b010, 3'b010,
                             16'hC000 + 16'(k - 1)));
        end
        tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, A0, A0, 16'h0, 3'b000, 3'b010, 16'hC003));

        // Reset in the second cycle of a locked client 1 burst.
        add_reset();
        tbl.push_back(mk(1, 3'b010, 3'b000, 3'b010, A0, A0, 16'h0, 3'b010, 3'b000, 16'h0));
        tbl.push_back(mk(0, 3'b011, 3'b000, 3'b010, A0, A0, 16'h0, 3'b000, 3'b010, 16'hBEEF));
        tbl.push_back(mk(0, 3'b011, 3'b000, 3'b010, A0, A0, 16'h0, 3'b000, 3'b000, 16'h0));
        tbl.push_back(mk(1, 3'b011, 3'b000, 3'b000, A0, A0, 16'h0, 3'b001, 3'b000, 16'h0));
        tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, A0, A0, 16'h0, 3'b000, 3'b001, 16'hBEEF));

        // Idle port for 10 cycles.
        for (int k = 0; k < 10; k++) begin
            tbl.push_back(mk(1, 3'b000, 3'b111, 3'b000, A0, A0, 16'h0, 3'b000, 3'b000, 16'h0));
        end

        foreach (tbl[i]) apply(i, tbl[i]);

        // Both clients 1 and 2 starved by client 0: client 1 first (rr=0), then
        // client 2 whose counter stayed saturated, then client 0 again.
        begin
            vec_t v;
            logic [2:0] g, prev;
            v = mk(0, 3'b000, 3'b000, 3'b000, A0, A0, 16'h0, 3'b000, 3'b000, 16'h0);
            v.chk_rv = 1'b0;
            apply(1000, v);
            apply(1001, mk(0, 3'b000, 3'b000, 3'b000, A0, A0, 16'h0, 3'b000, 3'b000, 16'h0));
            prev = 3'b000;
            for (int c = 0; c < 11; c++) begin
                g = (c == 8) ? 3'b010 : (c == 9) ? 3'b100 : 3'b001;
                apply(1100 + c, mk(1, 3'b111, 3'b000, 3'b000, A0, A0, 16'h0, g, prev, 16'hBEEF));
                prev = g;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_b_arbiter.md
# mem_b_arbiter

Shares memory port B between three requesters: client 0 is the VGA scan-out reader, client 1 is the SNES poller, and client 2 is the debug/program loader. The CPU FSM keeps exclusive use of port A. Each cycle the arbiter grants at most one single-word read or write and drives the block-RAM port B address, data and write-enable lines. Client 0 has fixed priority, clients 1 and 2 are protected from starvation by wait counters, and any client can lock the port for back-to-back bursts.

## Interface
- ADDR_WIDTH, 12, memory word-address width.
- MAX_WAIT, 8, number of waiting cycles after which client 1 or 2 overrides client 0 (range 1..15).

- clk  input  1  system clock. One clock domain; all state updates on posedge clk.
- reset  input  1  synchronous, active-low reset, sampled on posedge clk.
- req  input  3  per-client request. The client holds it, with its we, addr and wdata, stable until it is granted.
- we  input  3  per-client write (1) or read (0).
- lock  input  3  per-client request to keep the port after this grant.
- addr0, addr1, addr2  input  ADDR_WIDTH  per-client word address.
- wdata0, wdata1, wdata2  input  16  per-client write data.
- gnt  output  3  one-hot or zero grant, combinational from current state and inputs.
- rvalid  output  3  registered; high for client i the cycle after a read granted to client i.
- rdata  output  16  equal to mem_q_b; meaningful only while some rvalid bit is set.
- mem_addr_b  output  ADDR_WIDTH  address of the granted client, or 0 if none.
- mem_data_b  output  16  write data of the granted client, or 0 if none.
- mem_w_en_b  output  1  equal to |(gnt & we).
- mem_q_b  input  16  synchronous RAM read data, valid one cycle after the address.

## Operation
- Registered state:
  - wait1, wait2: 4-bit counters.
  - rr: 1 bit; 0 means client 1 is preferred, 1 means client 2 is preferred.
  - lock_valid, lock_owner[1:0].
  - rvalid.
- Grant selection, each cycle, in priority order. The first rule that applies wins:
  1. If lock_valid is set and req[lock_owner] is high, grant lock_owner.
  2. If client 1 and/or client 2 has req high and its wait counter equals MAX_WAIT, grant the starved client. If both are starved, rr decides.
  3. If req[0] is high, grant client 0.
  4. If client 1 and/or client 2 has req high, grant it. If both request, rr decides.
  5. Otherwise no grant.
- A request is accepted at the clock edge that ends the cycle in which its gnt bit is high. The client may change req, addr, we and wdata after that edge.
- rr update: when client 1 is granted, rr becomes 1 (client 2 preferred next). When client 2 is granted, rr becomes 0. A grant to client 0 leaves rr unchanged.
- wait_i update (i = 1, 2):
  - clears to 0 when client i is granted or req[i] is low;
  - otherwise increments by 1, saturating at MAX_WAIT.
- Lock handling:
  - Granting client i with lock[i]=1 sets lock_valid and lock_owner=i.
  - Granting the owner with lock=0 clears lock_valid.
  - The owner dropping req also clears lock_valid.
  - While the lock is held, all other clients wait, including client 0. Their wait counters still advance.
- rvalid next-state: rvalid[i] = gnt[i] & ~we[i].

## Timing
- Grant latency: 0 cycles. A request with no competition is granted in the same cycle req rises.
- Read data: address issued in cycle t; rvalid and rdata are valid in cycle t+1.
- Write: committed by the RAM at the edge that ends the grant cycle.
- Throughput: one transaction per cycle. A locked client gets consecutive grants.
- Reset (reset==0 at a posedge) produces this state after the edge:
  - wait1=wait2=0, rr=0, lock_valid=0, rvalid=0.
- While reset is low, gnt is forced to 0, mem_w_en_b=0, mem_addr_b=0 and mem_data_b=0.
- A transaction granted in the cycle where reset is sampled low is discarded. Its rvalid does not appear.
- Reset asserted during a locked burst releases the lock. Clients must re-request after reset.
- If no client requests, the port idles: mem_w_en_b=0 and all state holds, except that wait counters clear.

## Test plan
- Single read: client 1 reads addr 0x123 (RAM holds 0xBEEF) → gnt=3'b010 in the same cycle; next cycle rvalid=3'b010 and rdata=0xBEEF.
- Priority: client 0 and client 1 request simultaneously from cycle 0, and client 0 re-requests every cycle → client 0 is granted in cycles 0..7. Client 1 is granted in cycle 8 (wait1 reached 8 = MAX_WAIT), then wait1 clears.
- Round-robin: clients 1 and 2 hold req continuously, client 0 idle → grants alternate 010, 100, 010, … starting with client 1 after reset.
- Lock burst: client 2 writes 0x0A0..0x0A3 with lock=1 on the first three words and lock=0 on the last, while client 0 requests → four consecutive grants to client 2, then client 0 is granted. RAM then holds the four written values.
- Reset mid-burst: reset driven low in the second cycle of a locked client 1 burst → gnt=0 while reset is low. After release, lock_valid=0 and rvalid=0, and client 0 wins when it requests together with client 1.
- Idle/write-enable: no requests → mem_w_en_b=0, mem_addr_b=0, and rvalid stays 0 for 10 cycles.
